// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between two byte sources, the write arbiter and the FIFO write port.
// The master modport is the source/FIFO side; the slave modport is the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in0_data;
  logic                  in0_valid;
  logic                  in0_last;
  logic                  in0_ready;
  logic [DATA_WIDTH-1:0] in1_data;
  logic                  in1_valid;
  logic                  in1_last;
  logic                  in1_ready;
  logic                  fifo_full;
  logic                  sel;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_wr;
  logic                  out_last;
  logic                  busy;
  logic                  trunc_err;

  modport master (
    output in0_data, in0_valid, in0_last,
    output in1_data, in1_valid, in1_last,
    output fifo_full,
    input  in0_ready, in1_ready, sel, out_data, out_wr, out_last, busy, trunc_err
  );

  modport slave (
    input  in0_data, in0_valid, in0_last,
    input  in1_data, in1_valid, in1_last,
    input  fifo_full,
    output in0_ready, in1_ready, sel, out_data, out_wr, out_last, busy, trunc_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port between two byte sources.
// Grants are held for a whole packet; packets longer than MAX_PKT_LEN are cut with trunc_err.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_PKT_LEN = 2048,
  parameter int CNT_WIDTH   = 16
) (
  input logic              clk,
  input logic              reset,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_PKT_LEN - 1);

  state_t                state;
  logic                  prio;
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  transfer;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  at_limit;
  logic                  pkt_end;

  assign bus.in0_ready = (state == GRANT0) && !bus.fifo_full;
  assign bus.in1_ready = (state == GRANT1) && !bus.fifo_full;
  assign bus.busy      = (state != IDLE);

  always_comb begin
    transfer = 1'b0;
    g_last   = 1'b0;
    g_data   = '0;
    case (state)
      GRANT0: begin
        transfer = bus.in0_valid && bus.in0_ready;
        g_last   = bus.in0_last;
        g_data   = bus.in0_data;
      end
      GRANT1: begin
        transfer = bus.in1_valid && bus.in1_ready;
        g_last   = bus.in1_last;
        g_data   = bus.in1_data;
      end
      default: ;
    endcase
  end

  // The beat at LAST_BEAT closes the packet even without a source last flag.
  assign at_limit = (beat_cnt == LAST_BEAT);
  assign pkt_end  = transfer && (g_last || at_limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      prio          <= 1'b0;
      beat_cnt      <= '0;
      bus.sel       <= 1'b0;
      bus.out_data  <= '0;
      bus.out_wr    <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.trunc_err <= 1'b0;
    end else begin
      bus.out_wr    <= transfer;
      bus.out_last  <= pkt_end;
      bus.trunc_err <= transfer && at_limit && !g_last;
      if (transfer) begin
        bus.out_data <= g_data;
      end
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (bus.in0_valid && (!bus.in1_valid || !prio)) begin
            state   <= GRANT0;
            bus.sel <= 1'b0;
          end else if (bus.in1_valid) begin
            state   <= GRANT1;
            bus.sel <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          // Every packet end passes through IDLE and hands priority to the other source.
          if (pkt_end) begin
            state    <= IDLE;
            prio     <= (state == GRANT0);
            beat_cnt <= '0;
          end else if (transfer) begin
            beat_cnt <= beat_cnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table plus an output scoreboard,
// and a hand-written asynchronous-reset sequence.
module tb_fifo_wr_arbiter;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       full;
    logic       r0;
    logic       r1;
    logic       sel;
    logic       busy;
    logic       trunc;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       trunc;
    int         cycle;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_wr_arbiter_if #(.DATA_WIDTH(8)) bus ();

  fifo_wr_arbiter #(
    .DATA_WIDTH (8),
    .MAX_PKT_LEN(4),
    .CNT_WIDTH  (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic vec_t mk_vec(input int v0, input int d0, input int l0,
                                  input int v1, input int d1, input int l1,
                                  input int full, input int r0, input int r1,
                                  input int sel, input int busy, input int trunc);
    vec_t r;
    r.v0 = v0[0]; r.d0 = d0[7:0]; r.l0 = l0[0];
    r.v1 = v1[0]; r.d1 = d1[7:0]; r.l1 = l1[0];
    r.full = full[0]; r.r0 = r0[0]; r.r1 = r1[0];
    r.sel = sel[0]; r.busy = busy[0]; r.trunc = trunc[0];
    return r;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drive_idle();
    bus.in0_valid = 1'b0; bus.in0_data = 8'h00; bus.in0_last = 1'b0;
    bus.in1_valid = 1'b0; bus.in1_data = 8'h00; bus.in1_last = 1'b0;
    bus.fifo_full = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check_eq($sformatf("v%0d in0_ready", idx), bus.in0_ready, v.r0);
    check_eq($sformatf("v%0d in1_ready", idx), bus.in1_ready, v.r1);
    check_eq($sformatf("v%0d sel", idx), bus.sel, v.sel);
    check_eq($sformatf("v%0d busy", idx), bus.busy, v.busy);
    if (v.v0 && v.r0) sb.push_back('{v.d0, v.l0 | v.trunc, v.trunc, cyc + 1});
    if (v.v1 && v.r1) sb.push_back('{v.d1, v.l1 | v.trunc, v.trunc, cyc + 1});
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    bus.in0_valid = v.v0; bus.in0_data = v.d0; bus.in0_last = v.l0;
    bus.in1_valid = v.v1; bus.in1_data = v.d1; bus.in1_last = v.l1;
    bus.fifo_full = v.full;
    #1;
    checkOutput(v, idx);
  endtask

  // Scoreboard: every write must match the oldest accepted byte, one cycle after its accept.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && !reset) begin
      if (bus.out_wr) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL out_wr_unexpected: actual data=%0h cycle=%0d required no write",
                   bus.out_data, cyc);
        end else begin
          e = sb.pop_front();
          if ({bus.out_data, bus.out_last, bus.trunc_err} !== {e.data, e.last, e.trunc} ||
              cyc != e.cycle) begin
            failures++;
            $display("[TB] FAIL out_beat: actual data=%0h last=%0b trunc=%0b cycle=%0d required data=%0h last=%0b trunc=%0b cycle=%0d",
                     bus.out_data, bus.out_last, bus.trunc_err, cyc, e.data, e.last, e.trunc, e.cycle);
          end
        end
      end else if (sb.size() != 0 && sb[0].cycle <= cyc) begin
        checks++;
        failures++;
        e = sb.pop_front();
        $display("[TB] FAIL out_missing: actual no write at cycle %0d required data=%0h",
                 cyc, e.data);
      end else if (bus.trunc_err || bus.out_last) begin
        checks++;
        failures++;
        $display("[TB] FAIL out_qualify: actual last=%0b trunc=%0b required 0 without out_wr",
                 bus.out_last, bus.trunc_err);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // in0 four-byte packet, in1 idle
    vecs.push_back(mk_vec(1,'h11,0, 0,'h00,0, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(1,'h11,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'h22,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'h33,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'h44,1, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 0,'h00,0, 0, 0,0, 0,0, 0));
    // single-byte packets on both sources, priority now with in1
    vecs.push_back(mk_vec(1,'hC1,1, 1,'hD1,1, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(1,'hC1,1, 1,'hD1,1, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'hC1,1, 1,'hD2,1, 0, 0,0, 1,0, 0));
    vecs.push_back(mk_vec(1,'hC1,1, 1,'hD2,1, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hC2,1, 1,'hD2,1, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(1,'hC2,1, 1,'hD2,1, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hD3,1, 0, 0,0, 1,0, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hD3,1, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 0,'h00,0, 0, 0,0, 1,0, 0));
    // both sources continuously valid with 3-byte packets
    vecs.push_back(mk_vec(1,'hA1,0, 1,'hB1,0, 0, 0,0, 1,0, 0));
    vecs.push_back(mk_vec(1,'hA1,0, 1,'hB1,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hA2,0, 1,'hB1,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hA3,1, 1,'hB1,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hA4,0, 1,'hB1,0, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(1,'hA4,0, 1,'hB1,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'hA4,0, 1,'hB2,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'hA4,0, 1,'hB3,1, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'hA4,0, 1,'hB4,0, 0, 0,0, 1,0, 0));
    vecs.push_back(mk_vec(1,'hA4,0, 1,'hB4,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hA5,0, 1,'hB4,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hA6,1, 1,'hB4,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hB4,0, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hB4,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hB5,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hB6,1, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 0,'h00,0, 0, 0,0, 1,0, 0));
    // fifo_full for five cycles mid-packet, then valid drops for one cycle
    vecs.push_back(mk_vec(1,'hE1,0, 0,'h00,0, 0, 0,0, 1,0, 0));
    vecs.push_back(mk_vec(1,'hE1,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hE2,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk_vec(1,'hE3,0, 0,'h00,0, 1, 0,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hE3,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'hE4,1, 0,'h00,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 0,'h00,0, 0, 0,0, 0,0, 0));
    // in1 six-byte packet truncated at 4, in0 two-byte packet gets the next turn
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF1,0, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF1,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF2,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF3,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF4,0, 0, 0,1, 1,1, 1));
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF5,0, 0, 0,0, 1,0, 0));
    vecs.push_back(mk_vec(1,'h61,0, 1,'hF5,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(1,'h62,1, 1,'hF5,0, 0, 1,0, 0,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hF5,0, 0, 0,0, 0,0, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hF5,0, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 1,'hF6,1, 0, 0,1, 1,1, 0));
    vecs.push_back(mk_vec(0,'h00,0, 0,'h00,0, 0, 0,0, 1,0, 0));

    reset = 1'b1;
    drive_idle();
    @(negedge clk);
    #1;
    check_eq("rst sel", bus.sel, 1'b0);
    check_eq("rst out_wr", bus.out_wr, 1'b0);
    check_eq("rst out_data", bus.out_data, 8'h00);
    check_eq("rst out_last", bus.out_last, 1'b0);
    check_eq("rst trunc_err", bus.trunc_err, 1'b0);
    check_eq("rst busy", bus.busy, 1'b0);
    check_eq("rst ready", {bus.in0_ready, bus.in1_ready}, 2'b00);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Asynchronous reset between clock edges while in1 holds a grant
    @(negedge clk);
    bus.in1_valid = 1'b1; bus.in1_data = 8'h51; bus.in1_last = 1'b0;
    #1;
    check_eq("ar idle busy", bus.busy, 1'b0);
    @(negedge clk);
    #1;
    check_eq("ar grant in1_ready", bus.in1_ready, 1'b1);
    check_eq("ar grant sel", bus.sel, 1'b1);
    check_eq("ar grant busy", bus.busy, 1'b1);
    sb.push_back('{8'h51, 1'b0, 1'b0, cyc + 1});
    @(negedge clk);
    bus.in1_data = 8'h52;
    #1;
    check_eq("ar pre out_wr", bus.out_wr, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("ar out_wr", bus.out_wr, 1'b0);
    check_eq("ar in0_ready", bus.in0_ready, 1'b0);
    check_eq("ar in1_ready", bus.in1_ready, 1'b0);
    check_eq("ar busy", bus.busy, 1'b0);
    check_eq("ar sel", bus.sel, 1'b0);
    drive_idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.in1_valid = 1'b1; bus.in1_data = 8'h53; bus.in1_last = 1'b1;
    #1;
    check_eq("ar post busy", bus.busy, 1'b0);
    @(negedge clk);
    #1;
    check_eq("ar post in1_ready", bus.in1_ready, 1'b1);
    check_eq("ar post sel", bus.sel, 1'b1);
    check_eq("ar post busy1", bus.busy, 1'b1);
    sb.push_back('{8'h53, 1'b1, 1'b0, cyc + 1});
    @(negedge clk);
    drive_idle();
    #1;
    check_eq("ar end busy", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("sb drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
